// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// data-memory wait, debug halt (drain/hold/resume) and saturating statistics.
module pipeline_hazard_ctrl #(
   parameter int REG_NUM_WIDTH = 5,
   parameter int CNT_WIDTH     = 16,
   parameter int DRAIN_CYCLES  = 4,
   parameter int MEM_TIMEOUT   = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [REG_NUM_WIDTH-1:0] idRs,
   input  logic [REG_NUM_WIDTH-1:0] idRt,
   input  logic                     idUsesRs,
   input  logic                     idUsesRt,
   input  logic                     idexIsLoadInsn,
   input  logic                     idexRfWrEnable,
   input  logic [REG_NUM_WIDTH-1:0] idexDstReg,
   input  logic                     exBrTaken,
   input  logic                     memReq,
   input  logic                     memReady,
   input  logic                     haltReq,
   output logic                     pcStall,
   output logic                     ifidStall,
   output logic                     ifidFlush,
   output logic                     idexStall,
   output logic                     idexFlush,
   output logic                     exmemStall,
   output logic                     memwbFlush,
   output logic                     haltAck,
   output logic                     memTimeout,
   output logic [CNT_WIDTH-1:0]     stallCount,
   output logic [CNT_WIDTH-1:0]     flushCount,
   output logic [1:0]               state
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] MEM_WAIT = 2'd1;
   localparam logic [1:0] DRAIN    = 2'd2;
   localparam logic [1:0] HALTED   = 2'd3;

   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   logic [1:0]    ret_state;
   logic [DW-1:0] drain_cnt;
   logic [TW-1:0] wait_cnt;
   logic [TW-1:0] wait_next;
   logic          load_use;
   logic          mem_stall;
   logic          parked;

   assign mem_stall = memReq & ~memReady;
   assign load_use  = idexIsLoadInsn & idexRfWrEnable & (idexDstReg != '0) &
                      ((idUsesRs & (idRs == idexDstReg)) |
                       (idUsesRt & (idRt == idexDstReg)));

   // A memory wait entered from DRAIN keeps fetch parked once memory releases.
   assign parked = (state == DRAIN) || (state == HALTED) ||
                   ((state == MEM_WAIT) && (ret_state == DRAIN));

   always_comb begin
      pcStall    = 1'b0;
      ifidStall  = 1'b0;
      ifidFlush  = 1'b0;
      idexStall  = 1'b0;
      idexFlush  = 1'b0;
      exmemStall = 1'b0;
      memwbFlush = 1'b0;
      haltAck    = 1'b0;
      if (mem_stall) begin
         pcStall    = 1'b1;
         ifidStall  = 1'b1;
         idexStall  = 1'b1;
         exmemStall = 1'b1;
         memwbFlush = 1'b1;
      end else begin
         pcStall   = parked;
         ifidFlush = parked;
         haltAck   = (state == HALTED) && haltReq;
         if (exBrTaken) begin
            pcStall   = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
         end else if (load_use) begin
            pcStall   = 1'b1;
            ifidStall = 1'b1;
            ifidFlush = 1'b0;
            idexFlush = 1'b1;
         end
      end
   end

   // Counts consecutive frozen cycles, including the one that entered MEM_WAIT.
   always_comb begin
      wait_next = wait_cnt;
      case (state)
         RUN, DRAIN: if (mem_stall) wait_next = TW'(1);
         MEM_WAIT: begin
            if (!mem_stall)
               wait_next = '0;
            else if (wait_cnt != TW'(MEM_TIMEOUT))
               wait_next = wait_cnt + TW'(1);
         end
         default: wait_next = wait_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         ret_state  <= RUN;
         drain_cnt  <= '0;
         wait_cnt   <= '0;
         memTimeout <= 1'b0;
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         wait_cnt <= wait_next;
         if (wait_next >= TW'(MEM_TIMEOUT))
            memTimeout <= 1'b1;
         if (pcStall && (stallCount != '1))
            stallCount <= stallCount + CNT_WIDTH'(1);
         if (idexFlush && (flushCount != '1))
            flushCount <= flushCount + CNT_WIDTH'(1);

         case (state)
            RUN: begin
               if (mem_stall) begin
                  state     <= MEM_WAIT;
                  ret_state <= RUN;
               end else if (haltReq) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (!mem_stall)
                  state <= ret_state;
            end
            DRAIN: begin
               if (mem_stall) begin
                  state     <= MEM_WAIT;
                  ret_state <= DRAIN;
               end else if (!haltReq) begin
                  state <= RUN;
               end else if (exBrTaken) begin
                  drain_cnt <= '0;
               end else if (!load_use) begin
                  // Only clean bubble cycles advance the drain.
                  if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
                     state     <= HALTED;
                     drain_cnt <= '0;
                  end else begin
                     drain_cnt <= drain_cnt + DW'(1);
                  end
               end
            end
            HALTED: begin
               if (!haltReq)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
